// File: rtl/fsb_trace_replay_engine.sv
// Trace-driven sequencer: fetches opcode+payload commands from a combinational ROM,
// drives a valid/yumi stimulus channel and checks a valid/ready response channel.
module fsb_trace_replay_engine #(
    parameter int ring_width_p     = 32,
    parameter int rom_addr_width_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    input  logic                        v_i,
    input  logic [ring_width_p-1:0]     data_i,
    output logic                        ready_o,
    output logic                        v_o,
    output logic [ring_width_p-1:0]     data_o,
    input  logic                        yumi_i,
    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [ring_width_p+3:0]     rom_data_i,
    output logic                        done_o,
    output logic                        error_o
);

    // Handshakes: a stimulus beat transfers when v_o && yumi_i; a response beat
    // transfers when ready_o && v_i. Both are only offered in active cycles.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam logic [3:0] OP_WAIT      = 4'h0;
    localparam logic [3:0] OP_SEND      = 4'h1;
    localparam logic [3:0] OP_RECV      = 4'h2;
    localparam logic [3:0] OP_DONE      = 4'h3;
    localparam logic [3:0] OP_FINISH    = 4'h4;
    localparam logic [3:0] OP_COUNTDOWN = 4'h5;
    localparam logic [3:0] OP_LOADCNT   = 4'h6;

    state_e                      state_q, state_d;
    logic [rom_addr_width_p-1:0] addr_q, addr_d;
    logic [31:0]                 cnt_q, cnt_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;

    logic [3:0]                  opcode;
    logic [ring_width_p-1:0]     payload;
    logic                        active;

    assign opcode     = rom_data_i[ring_width_p+3:ring_width_p];
    assign payload    = rom_data_i[ring_width_p-1:0];
    assign active     = en_i && reset_i && (state_q == ST_RUN);
    assign rom_addr_o = addr_q;
    assign data_o     = payload;
    assign done_o     = done_q;
    assign error_o    = error_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        error_d = error_q;
        v_o     = 1'b0;
        ready_o = 1'b0;
        if (active) begin
            case (opcode)
                OP_WAIT: addr_d = addr_q + 1'b1;
                OP_SEND: begin
                    v_o = 1'b1;
                    if (yumi_i) addr_d = addr_q + 1'b1;
                end
                OP_RECV: begin
                    ready_o = 1'b1;
                    if (v_i) begin
                        addr_d = addr_q + 1'b1;
                        if (data_i != payload) error_d = 1'b1;
                    end
                end
                OP_DONE, OP_FINISH: begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
                OP_COUNTDOWN: begin
                    if (cnt_q == 32'd0) addr_d = addr_q + 1'b1;
                    else                cnt_d  = cnt_q - 32'd1;
                end
                OP_LOADCNT: begin
                    cnt_d  = 32'(payload);
                    addr_d = addr_q + 1'b1;
                end
                default: begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            cnt_q   <= 32'd0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_fsb_trace_replay_engine.sv
// Directed bench for fsb_trace_replay_engine: a behavioural ROM array feeds the
// engine; each task drives one scenario and checks hand-computed expectations.
module tb_fsb_trace_replay_engine;

  localparam int W  = 32;
  localparam int AW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          en_i;
  logic          v_i;
  logic [W-1:0]  data_i;
  logic          ready_o;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic          yumi_i;
  logic [AW-1:0] rom_addr_o;
  logic [W+3:0]  rom_data_i;
  logic          done_o;
  logic          error_o;

  logic [W+3:0]  rom_mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk_i = ~clk_i;

  assign rom_data_i = rom_mem[rom_addr_o];

  fsb_trace_replay_engine #(.ring_width_p(W), .rom_addr_width_p(AW)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  function automatic logic [W+3:0] ent(input logic [3:0] op, input logic [W-1:0] pl);
    return {op, pl};
  endfunction

  task automatic fill_rom(input logic [3:0] op);
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = ent(op, '0);
  endtask

  // hold reset for a few cycles, release on a falling edge
  task automatic do_reset(input logic en_after);
    @(negedge clk_i);
    reset_i = 1'b0;
    en_i    = 1'b0;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    en_i    = en_after;
  endtask

  task automatic test_reset;
    fill_rom(4'h3);
    rom_mem[0] = ent(4'h1, 32'h5);
    @(negedge clk_i);
    reset_i = 1'b0;
    en_i    = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({v_o, ready_o, rom_addr_o, done_o, error_o} !== {1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: v=%b rdy=%b addr=%0d done=%b err=%b, want 0/0/0/0/0",
                 i, v_o, ready_o, rom_addr_o, done_o, error_o);
      end
    end
    reset_i = 1'b1;
    #1;
    n_cmp++;
    if (v_o !== 1'b1 || data_o !== 32'h5) begin
      n_err++;
      $display("FAIL reset_release: v=%b data=%h, want 1 / 00000005", v_o, data_o);
    end
  endtask

  task automatic test_send_backpressure;
    fill_rom(4'h3);
    rom_mem[0] = ent(4'h1, 32'hA);
    rom_mem[1] = ent(4'h1, 32'hB);
    rom_mem[2] = ent(4'h3, 32'h0);
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (v_o !== 1'b1 || data_o !== 32'hA || rom_addr_o !== 8'd0) begin
        n_err++;
        $display("FAIL send_stall cyc %0d: v=%b data=%h addr=%0d, want 1/0000000a/0", i, v_o, data_o, rom_addr_o);
      end
    end
    yumi_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (v_o !== 1'b1 || data_o !== 32'hB || rom_addr_o !== 8'd1) begin
      n_err++;
      $display("FAIL send_second: v=%b data=%h addr=%0d, want 1/0000000b/1", v_o, data_o, rom_addr_o);
    end
    @(negedge clk_i);
    yumi_i = 1'b0;
    n_cmp++;
    if (v_o !== 1'b0 || rom_addr_o !== 8'd2) begin
      n_err++;
      $display("FAIL send_at_done_op: v=%b addr=%0d, want 0/2", v_o, rom_addr_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (done_o !== 1'b1 || rom_addr_o !== 8'd2 || error_o !== 1'b0 || v_o !== 1'b0) begin
      n_err++;
      $display("FAIL send_done: done=%b addr=%0d err=%b v=%b, want 1/2/0/0", done_o, rom_addr_o, error_o, v_o);
    end
  endtask

  task automatic test_recv_compare;
    fill_rom(4'h3);
    rom_mem[0] = ent(4'h2, 32'h10);
    rom_mem[1] = ent(4'h2, 32'h20);
    rom_mem[2] = ent(4'h3, 32'h0);
    do_reset(1'b1);
    @(negedge clk_i);
    n_cmp++;
    if (ready_o !== 1'b1 || rom_addr_o !== 8'd0 || v_o !== 1'b0) begin
      n_err++;
      $display("FAIL recv_first_ready: rdy=%b addr=%0d v=%b, want 1/0/0", ready_o, rom_addr_o, v_o);
    end
    v_i    = 1'b1;
    data_i = 32'h10;
    @(negedge clk_i);
    n_cmp++;
    if (ready_o !== 1'b1 || rom_addr_o !== 8'd1 || error_o !== 1'b0) begin
      n_err++;
      $display("FAIL recv_match: rdy=%b addr=%0d err=%b, want 1/1/0", ready_o, rom_addr_o, error_o);
    end
    data_i = 32'h21;
    @(negedge clk_i);
    v_i = 1'b0;
    n_cmp++;
    if (error_o !== 1'b1 || rom_addr_o !== 8'd2 || ready_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL recv_mismatch: err=%b addr=%0d rdy=%b done=%b, want 1/2/0/0", error_o, rom_addr_o, ready_o, done_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (done_o !== 1'b1 || error_o !== 1'b1) begin
      n_err++;
      $display("FAIL recv_done: done=%b err=%b, want 1/1", done_o, error_o);
    end
  endtask

  task automatic test_countdown;
    int at_one;
    fill_rom(4'h3);
    rom_mem[0] = ent(4'h6, 32'h3);
    rom_mem[1] = ent(4'h5, 32'h0);
    rom_mem[2] = ent(4'h3, 32'h0);
    do_reset(1'b1);
    at_one = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (rom_addr_o == 8'd1) at_one++;
      if (done_o) break;
    end
    n_cmp++;
    if (at_one !== 4 || done_o !== 1'b1 || error_o !== 1'b0) begin
      n_err++;
      $display("FAIL countdown: cycles_at_1=%0d done=%b err=%b, want 4/1/0", at_one, done_o, error_o);
    end
  endtask

  task automatic test_enable_gating;
    fill_rom(4'h3);
    rom_mem[0] = ent(4'h1, 32'h77);
    rom_mem[1] = ent(4'h3, 32'h0);
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (v_o !== 1'b0 || rom_addr_o !== 8'd0 || ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL enable_gated cyc %0d: v=%b addr=%0d rdy=%b, want 0/0/0", i, v_o, rom_addr_o, ready_o);
      end
      yumi_i = ~yumi_i;
    end
    @(negedge clk_i);
    yumi_i = 1'b0;
    en_i   = 1'b1;
    #1;
    n_cmp++;
    if (v_o !== 1'b1 || data_o !== 32'h77 || rom_addr_o !== 8'd0) begin
      n_err++;
      $display("FAIL enable_resume: v=%b data=%h addr=%0d, want 1/00000077/0", v_o, data_o, rom_addr_o);
    end
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
    n_cmp++;
    if (rom_addr_o !== 8'd1) begin
      n_err++;
      $display("FAIL enable_advance: addr=%0d, want 1", rom_addr_o);
    end
  endtask

  task automatic test_addr_wrap;
    fill_rom(4'h0);
    do_reset(1'b1);
    repeat (255) @(negedge clk_i);
    n_cmp++;
    if (rom_addr_o !== 8'd255) begin
      n_err++;
      $display("FAIL wrap_top: addr=%0d, want 255", rom_addr_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (rom_addr_o !== 8'd0 || done_o !== 1'b0 || error_o !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_zero: addr=%0d done=%b err=%b, want 0/0/0", rom_addr_o, done_o, error_o);
    end
  endtask

  task automatic test_illegal_and_async_reset;
    fill_rom(4'h3);
    rom_mem[0] = ent(4'h9, 32'h0);
    do_reset(1'b1);
    #1;
    n_cmp++;
    if (error_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_before: err=%b done=%b, want 0/0", error_o, done_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (error_o !== 1'b1 || done_o !== 1'b1 || v_o !== 1'b0 || rom_addr_o !== 8'd0) begin
      n_err++;
      $display("FAIL illegal_op: err=%b done=%b v=%b addr=%0d, want 1/1/0/0", error_o, done_o, v_o, rom_addr_o);
    end
    #2;
    reset_i = 1'b0;
    #1;
    n_cmp++;
    if (error_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: err=%b done=%b, want 0/0", error_o, done_o);
    end
  endtask

  initial begin
    reset_i = 1'b0;
    en_i    = 1'b0;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    test_reset();
    test_send_backpressure();
    test_recv_compare();
    test_countdown();
    test_enable_gating();
    test_addr_wrap();
    test_illegal_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
